// File: rtl/p_count_pkg.sv
// Shared types and constants for the pulse-count monitor.
package p_count_pkg;

  localparam int unsigned WIN_LEN_DEF = 16;
  localparam int unsigned CNT_W_DEF   = 8;
  localparam int unsigned WIN_LEN_MAX = 65535;
  localparam int unsigned TIMER_W     = $clog2(WIN_LEN_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_sync.sv
// Two-flop synchroniser plus previous-value flop; rise flags a synchronised 0->1.
module pulse_sync (
  input  logic clk,
  input  logic clear_n,
  input  logic async_in,
  output logic rise
);

  logic meta;
  logic synced;
  logic prev;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      meta   <= 1'b0;
      synced <= 1'b0;
      prev   <= 1'b0;
    end else begin
      meta   <= async_in;
      synced <= meta;
      prev   <= synced;
    end
  end

  assign rise = synced & ~prev;

endmodule

// File: rtl/p_count_monitor.sv
// Counts rising edges of pulse_in over fixed WIN_LEN-cycle windows and reports each result.
module p_count_monitor
  import p_count_pkg::*;
#(
  parameter int unsigned WIN_LEN = WIN_LEN_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             enable,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             cnt_valid,
  output logic             overflow,
  output logic             busy
);

  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   acc;
  logic [CNT_W-1:0]   acc_next;
  logic [CNT_W-1:0]   acc_sum;
  logic               win_ovf;
  logic               win_ovf_next;
  logic               hit_ovf;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_next;
  logic [CNT_W-1:0]   edge_cnt_next;
  logic               overflow_next;
  logic               valid_next;
  logic               rise;

  pulse_sync u_sync (
    .clk      (clk),
    .clear_n  (clear_n),
    .async_in (pulse_in),
    .rise     (rise)
  );

  // Saturating accumulate; an edge arriving at full scale marks the window overflowed.
  always_comb begin
    acc_sum = acc;
    hit_ovf = 1'b0;
    if (rise) begin
      if (acc == CNT_MAX) begin
        hit_ovf = 1'b1;
      end else begin
        acc_sum = acc + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state     <= IDLE;
      acc       <= '0;
      win_ovf   <= 1'b0;
      timer     <= '0;
      edge_cnt  <= '0;
      overflow  <= 1'b0;
      cnt_valid <= 1'b0;
    end else begin
      state     <= state_next;
      acc       <= acc_next;
      win_ovf   <= win_ovf_next;
      timer     <= timer_next;
      edge_cnt  <= edge_cnt_next;
      overflow  <= overflow_next;
      cnt_valid <= valid_next;
    end
  end

  always_comb begin
    state_next    = state;
    acc_next      = acc;
    win_ovf_next  = win_ovf;
    timer_next    = timer;
    edge_cnt_next = edge_cnt;
    overflow_next = overflow;
    valid_next    = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_next = ARM;
        end
      end
      ARM: begin
        if (!enable) begin
          state_next = IDLE;
        end else begin
          acc_next     = '0;
          win_ovf_next = 1'b0;
          timer_next   = TIMER_LOAD;
          state_next   = MEASURE;
        end
      end
      MEASURE: begin
        // Terminal cycle reports even if enable just dropped; otherwise enable=0 aborts.
        if (timer == '0) begin
          edge_cnt_next = acc_sum;
          overflow_next = win_ovf | hit_ovf;
          valid_next    = 1'b1;
          acc_next      = '0;
          win_ovf_next  = 1'b0;
          if (enable) begin
            timer_next = TIMER_LOAD;
          end else begin
            state_next = IDLE;
          end
        end else if (!enable) begin
          state_next = IDLE;
        end else begin
          acc_next     = acc_sum;
          win_ovf_next = win_ovf | hit_ovf;
          timer_next   = timer - TIMER_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state == ARM) || (state == MEASURE);

endmodule

// File: doc/p_count_monitor.md
P_COUNT_MONITOR -- requirements
Module: p_count_monitor

Interface
REQ-001 Parameter WIN_LEN, default 16, measurement window length in clk cycles (legal range 2..65535).
REQ-002 Parameter CNT_W, default 8, width of the reported edge count (legal range 2..16).
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 clear_n  input  1  reset, asynchronous and active-low (asserted at 0).
REQ-005 enable  input  1  level; 1 = run measurement windows, 0 = abort and idle.
REQ-006 pulse_in  input  1  asynchronous to clk; this is the p_counter count output (the signal being monitored).
REQ-007 edge_cnt  output  CNT_W  rising edges of pulse_in counted in the last completed window.
REQ-008 cnt_valid  output  1  one-cycle strobe; edge_cnt and overflow are updated in that cycle.
REQ-009 overflow  output  1  the last completed window saturated at 2^CNT_W-1.
REQ-010 busy  output  1  high in states ARM and MEASURE.

Function
REQ-011 The synchroniser SHALL pass pulse_in through 2 flops, and a third flop SHALL hold the previous synchronised value.
REQ-012 A rising edge SHALL be detected as synced=1 and prev=0; the latency from a pulse_in edge to edge detection is 3 clk cycles.
REQ-013 The FSM SHALL have exactly 3 states: IDLE, ARM and MEASURE.
REQ-014 In IDLE, enable=1 SHALL move the FSM to ARM on the next edge.
REQ-015 ARM SHALL last exactly 1 cycle; it SHALL clear the accumulator, load the window timer with WIN_LEN-1 and move to MEASURE.
- No edge is counted in ARM.
- A pulse_in level that is already high is therefore not counted.
REQ-016 In MEASURE, each cycle SHALL add the detected edge to the accumulator and decrement the timer.
REQ-017 The accumulator SHALL saturate at 2^CNT_W-1; an edge arriving while saturated SHALL set a sticky window-overflow flag.
REQ-018 The terminal cycle is the cycle with timer=0; on that cycle, with edges counted:
- edge_cnt SHALL load acc+edge (saturating).
- overflow SHALL load the window flag, including saturation in this cycle.
- cnt_valid SHALL be 1 in the following cycle only.
REQ-019 If enable=1 at the terminal cycle, the next window SHALL start back-to-back.
- The timer reloads to WIN_LEN-1.
- The accumulator and flag clear.
- Every window is exactly WIN_LEN cycles, with no gap.
REQ-020 If enable=0 at the terminal cycle, the result SHALL still be reported and the FSM SHALL go to IDLE.
REQ-021 If enable=0 in MEASURE on a non-terminal cycle, or at any time in ARM, the FSM SHALL abort to IDLE.
- No cnt_valid is produced.
- edge_cnt and overflow keep their previous values.
REQ-022 edge_cnt and overflow SHALL change only on a cnt_valid cycle.

Reset
REQ-023 While clear_n=0, the following SHALL apply immediately, without waiting for clk:
- FSM=IDLE.
- edge_cnt=0, cnt_valid=0, overflow=0, busy=0.
- Accumulator, timer and all synchroniser flops = 0.
REQ-024 When clear_n is asserted mid-window, the partial count SHALL be discarded and no cnt_valid SHALL be produced.
REQ-025 After clear_n deasserts, with enable=1, the first MEASURE cycle SHALL be the second clk edge.

Structure
REQ-026 A shared package p_count_pkg SHALL hold the following:
- The FSM state enum (IDLE/ARM/MEASURE).
- Default values of WIN_LEN and CNT_W.
- The timer width constant, defined as $clog2 of the WIN_LEN maximum.
REQ-027 One sub-module, pulse_sync, SHALL contain the 2-flop synchroniser, the prev flop and the edge detect.
- Its ports are clk, clear_n, async_in and rise.
REQ-028 The expected RTL size is 120-400 lines in total.

Verification (WIN_LEN=16, CNT_W=8 unless stated)
REQ-029 Reset: hold clear_n=0 with pulse_in toggling.
- edge_cnt=0, cnt_valid=0, overflow=0, busy=0 throughout.
- The values SHALL also be 0 within the same timestep when clear_n is asserted between clk edges.
REQ-030 pulse_in toggles every clk (period 2) with enable=1 continuously.
- Every window: edge_cnt=8, overflow=0.
- cnt_valid SHALL pulse every 16 cycles.
REQ-031 pulse_in is held at 1 before enable rises and stays at 1.
- The first window: edge_cnt=0.
REQ-032 Overflow, with CNT_W=3 and pulse_in period 2:
- edge_cnt=7, overflow=1.
- A following window with pulse_in period 4 SHALL report edge_cnt=4, overflow=0.
REQ-033 Abort: enable drops at cycle 5 of a window.
- No cnt_valid.
- edge_cnt keeps its previous value (for example 8).
- busy=0 on the next cycle.
REQ-034 Reset mid-window: pulse clear_n low at cycle 9 of MEASURE.
- Outputs go to 0 immediately.
- After release with enable=1, the first report comes 1+16 cycles later and shows that full window's count.
